// File: rtl/sram_pkg.sv
// Shared definitions for the external SRAM controller: FSM states and SRAM geometry.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int unsigned SRAM_BASE_ADDR = 1024;
    localparam int unsigned SRAM_HALF_W    = 16;
    localparam int unsigned SRAM_ADDR_W    = 18;

    // Hold counters need at least one bit even when each half lasts a single cycle.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter that times how long each SRAM half access is held.
// tc is high when the count has reached zero, i.e. in the last cycle of a hold.
module sram_wait_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// sram_controller: MEM-stage LDR/STR access to a 256K x 16 asynchronous SRAM, each 32-bit word as two half accesses.
// Define SRAM_ADDR_CHECK_EN to reject out-of-range/misaligned requests and raise a sticky addr_err.
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned BASE_ADDR     = SRAM_BASE_ADDR,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned ADDR_W        = SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_HALF_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0]      SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
`ifdef SRAM_ADDR_CHECK_EN
    ,
    output logic                   addr_err
`endif
);

    localparam int unsigned CNT_W = cnt_width(ACCESS_CYCLES);
    localparam logic [31:0] BASE  = 32'(BASE_ADDR);
    localparam bit          MULTI = (ACCESS_CYCLES > 1);

    sram_state_t              state;
    logic                     op_wr;
    logic [ADDR_W-2:0]        word_q;
    logic [SRAM_HALF_W-1:0]   wdata_hi;
    logic [SRAM_HALF_W-1:0]   dq_out;
    logic                     dq_oe;
    logic [31:0]              addr_diff;
    logic [ADDR_W-2:0]        word_addr;
    logic                     req;
    logic                     req_go;
    logic                     cnt_load;
    logic                     cnt_en;
    logic [CNT_W-1:0]         cnt;
    logic                     cnt_tc;

    assign addr_diff = address - BASE;
    assign word_addr = addr_diff[ADDR_W:2];
    assign req       = wr_en | rd_en;

`ifdef SRAM_ADDR_CHECK_EN
    logic addr_bad;
    assign addr_bad = (address < BASE) || (address[1:0] != 2'b00) || (addr_diff[31:ADDR_W+1] != '0);
    assign req_go   = req && !addr_bad;
`else
    assign req_go   = req;
`endif

    assign cnt_load = ((state == IDLE) && req_go) || ((state == LO) && cnt_tc);
    assign cnt_en   = (state == LO) || (state == HI);

    sram_wait_counter #(
        .W(CNT_W)
    ) u_wait (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .en        (cnt_en),
        .load_value(CNT_W'(ACCESS_CYCLES - 1)),
        .count     (cnt),
        .tc        (cnt_tc)
    );

    // WE_N is registered one cycle ahead: it rises for the last cycle of each half so data is held past the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            word_q    <= '0;
            wdata_hi  <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_go) begin
                        state     <= LO;
                        op_wr     <= wr_en;
                        word_q    <= word_addr;
                        wdata_hi  <= write_data[31:16];
                        dq_out    <= write_data[15:0];
                        dq_oe     <= wr_en;
                        SRAM_ADDR <= {word_addr, 1'b0};
                        SRAM_WE_N <= !(wr_en && MULTI);
                    end
                end
                LO: begin
                    if (cnt_tc) begin
                        if (!op_wr) begin
                            read_data[15:0] <= SRAM_DQ;
                        end
                        state     <= HI;
                        dq_out    <= wdata_hi;
                        SRAM_ADDR <= {word_q, 1'b1};
                        SRAM_WE_N <= !(op_wr && MULTI);
                    end else begin
                        SRAM_WE_N <= !(op_wr && (cnt != CNT_W'(1)));
                    end
                end
                HI: begin
                    if (cnt_tc) begin
                        if (!op_wr) begin
                            read_data[31:16] <= SRAM_DQ;
                        end
                        state     <= DONE;
                        dq_oe     <= 1'b0;
                        SRAM_WE_N <= 1'b1;
                    end else begin
                        SRAM_WE_N <= !(op_wr && (cnt != CNT_W'(1)));
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if ((state == IDLE) && req && addr_bad) begin
            addr_err <= 1'b1;
        end
    end
`endif

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = !req_go;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_HALF_W{1'bz}};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: random LDR/STR traffic against a behavioural SRAM, word-level reference and scoreboard.
// Exercises the SRAM_ADDR_CHECK_EN checks when that macro is defined for the build.
`timescale 1ns/1ps
module tb_sram_controller;

    localparam int AC     = 2;
    localparam int BASE   = 1024;
    localparam int ADDR_W = 18;
    localparam int LAT    = 2 * AC + 1;

    typedef struct {
        bit          is_read;
        logic [31:0] exp_rd;
        int          word;
        logic [31:0] wdata;
    } sb_item_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              ready;
    wire  [15:0]       sram_dq;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we_n;
    logic              sram_ub_n;
    logic              sram_lb_n;
    logic              sram_ce_n;
    logic              sram_oe_n;
`ifdef SRAM_ADDR_CHECK_EN
    logic              addr_err;
`endif

    int          checks = 0;
    int          passes = 0;
    sb_item_t    sb[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_read;
    logic [15:0] sram_mem [0:(1 << ADDR_W) - 1];
    logic        rd_window;
    logic        mem_init;
    int          low_run;
    int          we_low;

    always #5 clk = ~clk;

    sram_controller #(
        .BASE_ADDR    (BASE),
        .ACCESS_CYCLES(AC),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n)
`ifdef SRAM_ADDR_CHECK_EN
        ,
        .addr_err  (addr_err)
`endif
    );

    function automatic logic [15:0] init_half(input int i);
        return 16'((i * 40503) ^ (i >> 2) ^ 32'h5A5A);
    endfunction

    // Behavioural asynchronous SRAM: drives the bus only while the bench has a load outstanding.
    assign sram_dq = (rd_window && sram_we_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) begin
                sram_mem[i] <= init_half(i);
            end
        end else if (!sram_we_n && !sram_ce_n) begin
            sram_mem[sram_addr] <= sram_dq;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one request from a posedge+1 position and returns at posedge+1 after the pipeline advances.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr,
                                 input logic [31:0] data, input bit scramble);
        sb_item_t item;
        bit       got;
        int       w;
        w          = int'((addr - 32'(BASE)) / 4);
        item.word  = w;
        item.wdata = data;
        if (wr) begin
            item.is_read = 1'b0;
            item.exp_rd  = last_read;
            ref_mem[w]   = data;
        end else begin
            item.is_read = 1'b1;
            item.exp_rd  = ref_mem[w];
            last_read    = ref_mem[w];
        end
        sb.push_back(item);
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
        rd_window  = rd && !wr;
        got        = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
            if (scramble && c > 0) begin
                address    = 32'd2000;
                write_data = $urandom;
            end
        end
        if (!got) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_window = 1'b0;
    endtask

    // Monitor: a completed access is a rise of ready after a run of ready-low cycles.
    initial begin
        sb_item_t    item;
        logic [15:0] lo_half;
        logic [15:0] hi_half;
        low_run = 0;
        we_low  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_run = 0;
                we_low  = 0;
            end else if (!ready) begin
                low_run++;
                if (!sram_we_n) begin
                    we_low++;
                end
            end else if (low_run > 0) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    item = sb.pop_front();
                    checkOutput("latency", 32'(low_run), 32'(LAT));
                    checkOutput("read_data", read_data, item.exp_rd);
                    if (item.is_read) begin
                        checkOutput("rd_we_low", 32'(we_low), 32'd0);
                    end else begin
                        lo_half = sram_mem[2 * item.word];
                        hi_half = sram_mem[2 * item.word + 1];
                        checkOutput("wr_we_low", 32'(we_low), 32'(2 * (AC - 1)));
                        checkOutput("wr_lo_half", {16'h0, lo_half}, {16'h0, item.wdata[15:0]});
                        checkOutput("wr_hi_half", {16'h0, hi_half}, {16'h0, item.wdata[31:16]});
                    end
                end
                low_run = 0;
                we_low  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ref_w;
        logic [31:0] saved_addr;
        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = '0;
        write_data = '0;
        rd_window  = 1'b0;
        mem_init   = 1'b1;
        last_read  = '0;
        for (int w = 0; w < 256; w++) begin
            ref_mem[w] = {init_half(2 * w + 1), init_half(2 * w)};
        end
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, ready}, 32'd1);
        checkOutput("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        checkOutput("rst_read_data", read_data, 32'd0);
        checkOutput("rst_sram_addr", 32'(sram_addr), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);

        applyStimulus(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b1);
        ref_w = ref_mem[244];
        checkOutput("latch_stray_lo", {16'h0, sram_mem[488]}, {16'h0, ref_w[15:0]});
        checkOutput("latch_stray_hi", {16'h0, sram_mem[489]}, {16'h0, ref_w[31:16]});
        applyStimulus(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int unsigned w;
            bit          wr;
            bit          rd;
            w  = $urandom_range(0, 127);
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(wr, rd, 32'(BASE) + 32'(w * 4), $urandom, 1'b0);
        end

        wr_en      = 1'b1;
        address    = 32'(BASE + 800);
        write_data = $urandom;
        @(posedge clk);
        #3;
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        checkOutput("midrst_ready", {31'd0, ready}, 32'd1);
        checkOutput("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
        checkOutput("midrst_read_data", read_data, 32'd0);
        checkOutput("midrst_sram_addr", 32'(sram_addr), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        last_read = '0;
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

`ifdef SRAM_ADDR_CHECK_EN
        saved_addr = 32'(sram_addr);
        rd_en      = 1'b1;
        address    = 32'd1022;
        @(negedge clk);
        checkOutput("err_ready_same_cycle", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        checkOutput("err_flag_set", {31'd0, addr_err}, 32'd1);
        checkOutput("err_no_sram_addr", 32'(sram_addr), saved_addr);
        checkOutput("err_read_data_kept", read_data, last_read);
        applyStimulus(1'b0, 1'b1, 32'd1044, 32'h0, 1'b0);
        checkOutput("err_flag_sticky", {31'd0, addr_err}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("err_flag_cleared", {31'd0, addr_err}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        last_read = '0;
`else
        saved_addr = '0;
`endif

        repeat (4) @(posedge clk);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
